// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: FSM states,
// instruction field positions and write-select codes.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } seq_state_e;

    localparam int BIT_JMP  = 31;
    localparam int BIT_BR   = 30;
    localparam int WSEL_HI  = 29;
    localparam int WSEL_LO  = 28;
    localparam int ALUOP_HI = 27;
    localparam int ALUOP_LO = 23;
    localparam int RA1_HI   = 22;
    localparam int RA1_LO   = 18;
    localparam int RA2_HI   = 17;
    localparam int RA2_LO   = 13;
    localparam int CONST_HI = 12;
    localparam int CONST_LO = 5;
    localparam int WA_HI    = 4;
    localparam int WA_LO    = 0;

    typedef enum logic [1:0] {
        WSEL_NONE  = 2'b00,
        WSEL_RSVD  = 2'b01,
        WSEL_ALU   = 2'b10,
        WSEL_CONST = 2'b11
    } wsel_e;

endpackage

// File: rtl/seq_decode.sv
// Combinational decode of the latched instruction's control bits into
// write-enable, write-data select, reserved-code detect and branch decision.
module seq_decode
    import seq_pkg::*;
(
    input  logic [BIT_JMP:WSEL_LO] ir_ctrl,
    input  logic                   flag_q,
    output logic                   wr_en,
    output logic                   wd_sel,
    output logic                   illegal_op,
    output logic                   take_branch
);

    wsel_e wsel;

    assign wsel        = wsel_e'(ir_ctrl[WSEL_HI:WSEL_LO]);
    assign wr_en       = (wsel == WSEL_ALU) || (wsel == WSEL_CONST);
    assign wd_sel      = ir_ctrl[WSEL_LO];
    assign illegal_op  = (wsel == WSEL_RSVD);
    // An unconditional jump wins even when the branch bit is also set.
    assign take_branch = ir_ctrl[BIT_JMP] | (ir_ctrl[BIT_BR] & flag_q);

endmodule

// File: rtl/instr_sequencer.sv
// FETCH/EXEC/WB control unit owning the PC, instruction register and retire
// counter. Optional single-step input is enabled by defining SEQ_STEP_EN.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SEQ_STEP_EN
    input  logic               step,
`endif
    input  logic               halt_req,
    input  logic [INSTR_W-1:0] instr,
    input  logic               alu_flag,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               rf_we,
    output logic               wd_sel,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    seq_state_e         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               flag_q, flag_d;
    logic               halted_q, halted_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               step_run_q, step_run_d;

    logic               dec_wr_en, dec_wd_sel, dec_illegal, dec_take;
    logic               stop_after_wb;
    logic [PC_W-1:0]    br_off;

    seq_decode u_decode (
        .ir_ctrl     (ir_q[BIT_JMP:WSEL_LO]),
        .flag_q      (flag_q),
        .wr_en       (dec_wr_en),
        .wd_sel      (dec_wd_sel),
        .illegal_op  (dec_illegal),
        .take_branch (dec_take)
    );

    // Offset is unsigned; the PC wraps modulo 2**PC_W.
    assign br_off = PC_W'(ir_q[CONST_HI:CONST_LO]);

`ifdef SEQ_STEP_EN
    assign stop_after_wb = halt_req | step_run_q;
`else
    assign stop_after_wb = halt_req;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        flag_d     = flag_q;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        retired_d  = retired_q;
        step_run_d = step_run_q;
        rf_we      = 1'b0;
        wd_sel     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    halted_d   = 1'b0;
                    step_run_d = 1'b0;
                end
`ifdef SEQ_STEP_EN
                else if (step) begin
                    state_d    = ST_FETCH;
                    halted_d   = 1'b0;
                    step_run_d = 1'b1;
                end
`endif
            end
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                flag_d  = alu_flag;
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we     = dec_wr_en;
                wd_sel    = dec_wd_sel;
                illegal_d = illegal_q | dec_illegal;
                pc_d      = dec_take ? (pc_q + br_off) : (pc_q + PC_W'(1));
                retired_d = retired_q + CNT_W'(1);
                if (stop_after_wb) begin
                    state_d  = ST_IDLE;
                    halted_d = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            flag_q     <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
            step_run_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            flag_q     <= flag_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
            retired_q  <= retired_d;
            step_run_q <= step_run_d;
        end
    end

    assign pc      = pc_q;
    assign ir      = ir_q;
    assign busy    = (state_q != ST_IDLE);
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an instruction-level model predicts
// register writes and retirements; a negedge monitor checks them.
module tb_instr_sequencer;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               halt_req;
    logic [INSTR_W-1:0] instr;
    logic               alu_flag;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               rf_we;
    logic               wd_sel;
    logic               busy;
    logic               halted;
    logic               illegal;
    logic [CNT_W-1:0]   retired;
`ifdef SEQ_STEP_EN
    logic               step;
`endif

    logic [31:0] imem [256];

    always #5 clk = ~clk;

    // Combinational instruction memory; the bench's ALU flag is ir[23].
    assign instr    = imem[pc];
    assign alu_flag = ir[23];

    instr_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef SEQ_STEP_EN
        .step     (step),
`endif
        .halt_req (halt_req),
        .instr    (instr),
        .alu_flag (alu_flag),
        .pc       (pc),
        .ir       (ir),
        .rf_we    (rf_we),
        .wd_sel   (wd_sel),
        .busy     (busy),
        .halted   (halted),
        .illegal  (illegal),
        .retired  (retired)
    );

    typedef struct {
        logic [31:0] word;
        logic        sel;
    } wr_exp_t;

    typedef struct {
        logic [7:0]       npc;
        logic [CNT_W-1:0] cnt;
        logic             ill;
    } rt_exp_t;

    wr_exp_t wr_q[$];
    rt_exp_t rt_q[$];
    wr_exp_t we_item;
    rt_exp_t rt_item;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]       m_pc;
    logic [CNT_W-1:0] m_ret;
    logic             m_ill;
    logic [CNT_W-1:0] prev_ret;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pc  = 8'd0;
        m_ret = '0;
        m_ill = 1'b0;
        wr_q.delete();
        rt_q.delete();
    endtask

    // One whole instruction at the ISA level: write, illegal flag, next pc, count.
    task automatic modelStep();
        logic [31:0] w;
        logic        flag;
        w    = imem[m_pc];
        flag = w[23];
        if (w[29]) wr_q.push_back('{word: w, sel: w[28]});
        if (w[29:28] == 2'b01) m_ill = 1'b1;
        if (w[31] || (w[30] && flag)) m_pc = m_pc + w[12:5];
        else                          m_pc = m_pc + 8'd1;
        m_ret = m_ret + 1'b1;
        rt_q.push_back('{npc: m_pc, cnt: m_ret, ill: m_ill});
    endtask

    // Runs n instructions with start; halt_req is raised in FETCH or EXEC of the
    // last one, and short cancelled halt pulses / ignored starts happen earlier.
    task automatic applyStimulus(input int n);
        bit last;
        for (int i = 0; i < n; i++) modelStep();
        @(posedge clk); #1;
        start    = 1'b1;
        halt_req = (n == 1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1);
            if (last) halt_req = halt_req | ($urandom_range(0, 1) == 1);
            else      halt_req = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            if (last) halt_req = 1'b1;
            else begin
                halt_req = 1'b0;
                start    = ($urandom_range(0, 3) == 0);
            end
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            if (last) halt_req = 1'b0;
        end
        checkOutput("halted_after_run", 32'(halted), 32'd1);
        checkOutput("busy_after_run", 32'(busy), 32'd0);
    endtask

    task automatic resetMidExec();
        for (int i = 0; i < 3; i++) modelStep();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_retired", 32'(retired), 32'd0);
        checkOutput("rst_ir", ir, 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: a write pulse pops the write queue, a count change pops the retire queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_ret = '0;
        end else begin
            if (rf_we) begin
                if (wr_q.size() == 0) begin
                    checkOutput("spurious_rf_we", 32'(rf_we), 32'd0);
                end else begin
                    we_item = wr_q.pop_front();
                    checkOutput("wb_wd_sel", 32'(wd_sel), 32'(we_item.sel));
                    checkOutput("wb_ir", ir, we_item.word);
                end
            end
            if (retired != prev_ret) begin
                if (rt_q.size() == 0) begin
                    checkOutput("spurious_retire", 32'(retired), 32'(prev_ret));
                end else begin
                    rt_item = rt_q.pop_front();
                    checkOutput("retire_pc", 32'(pc), 32'(rt_item.npc));
                    checkOutput("retire_count", 32'(retired), 32'(rt_item.cnt));
                    checkOutput("retire_illegal", 32'(illegal), 32'(rt_item.ill));
                end
                prev_ret = retired;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        rst      = 1'b1;
        start    = 1'b0;
        halt_req = 1'b0;
`ifdef SEQ_STEP_EN
        step     = 1'b0;
`endif
        prev_ret = '0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0000;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_pc", 32'(pc), 32'd0);
        checkOutput("reset_ir", ir, 32'd0);
        checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("reset_wd_sel", 32'(wd_sel), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_illegal", 32'(illegal), 32'd0);
        checkOutput("reset_retired", 32'(retired), 32'd0);
        rst = 1'b0;

        imem[0]   = 32'h3000_0001;
        imem[1]   = 32'h2000_0002;
        imem[2]   = 32'h8000_0100;
        imem[10]  = 32'h4080_00A0;
        imem[15]  = 32'h8000_1F60;
        imem[11]  = 32'h8000_1DE0;
        imem[250] = 32'hC000_0140;
        imem[4]   = 32'h8000_1F60;
        imem[255] = 32'h2000_0007;
        $display("[TB] directed: const/ALU writes, branch taken");
        applyStimulus(2);
        applyStimulus(2);
        $display("[TB] directed: branch not taken, wrap-around jumps");
        imem[10] = 32'h4000_00A0;
        applyStimulus(2);
        applyStimulus(4);
        $display("[TB] directed: start with halt, reserved write select");
        applyStimulus(1);
        imem[1] = 32'h1000_0003;
        applyStimulus(1);
        applyStimulus(2);
        $display("[TB] directed: reset during EXEC");
        resetMidExec();

        $display("[TB] random programs");
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if (w[29:28] == 2'b01 && $urandom_range(0, 7) != 0) w[29] = 1'b1;
            imem[i] = w;
        end
        for (int r = 0; r < 30; r++) applyStimulus($urandom_range(1, 8));

`ifdef SEQ_STEP_EN
        $display("[TB] single step");
        for (int s = 0; s < 3; s++) begin
            modelStep();
            @(posedge clk); #1;
            step = 1'b1;
            @(posedge clk); #1;
            step = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            checkOutput("step_halted", 32'(halted), 32'd1);
            checkOutput("step_busy", 32'(busy), 32'd0);
        end
`endif

        repeat (4) @(posedge clk);
        #1;
        checkOutput("write_queue_drained", 32'(wr_q.size()), 32'd0);
        checkOutput("retire_queue_drained", 32'(rt_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
